axi_burst_mem_slave: RTL
========================

# axi_burst_mem_slave
Synthesizable AXI4 memory slave that terminates the passthrough VIP's master-side port in the example design, taking the place of the passive slave VIP as a real memory endpoint. It accepts INCR bursts on independent write and read paths and stores data in an internal word array with byte strobes. Non-INCR bursts receive SLVERR. The block gives the scoreboard a deterministic, cycle-exact responder.
## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data bus width; BYTES = DATA_WIDTH/8; full-width beats only (AxSIZE fixed, not a port)
- DEPTH, 1024, memory depth in words; power of two
- clock  in  1  single clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- s_awaddr  in  ADDR_WIDTH  write burst start address
- s_awlen  in  8  beats minus one
- s_awburst  in  2  burst type; only INCR (2'b01) is writable
- s_awvalid  in  1  AW valid
- s_awready  out  1  AW ready
- s_wdata  in  DATA_WIDTH  write data
- s_wstrb  in  BYTES  byte enables
- s_wlast  in  1  last write beat
- s_wvalid  in  1  W valid
- s_wready  out  1  W ready
- s_bresp  out  2  write response
- s_bvalid  out  1  B valid
- s_bready  in  1  B ready
- s_araddr  in  ADDR_WIDTH  read burst start address
- s_arlen  in  8  beats minus one
- s_arburst  in  2  burst type; only INCR is readable
- s_arvalid  in  1  AR valid
- s_arready  out  1  AR ready
- s_rdata  out  DATA_WIDTH  read data
- s_rresp  out  2  read response
- s_rlast  out  1  last read beat
- s_rvalid  out  1  R valid
- s_rready  in  1  R ready
## Operation
- **Word index:** addr[log2(DEPTH)+log2(BYTES)-1 : log2(BYTES)]. Upper bits and low byte-offset bits are ignored. Each beat increments the index modulo DEPTH, so the index wraps from DEPTH-1 to 0.
- **Write FSM, W_IDLE:** s_awready=1. An AW handshake captures index, len and burst, clears the beat counter, and moves to W_DATA.
- **Write FSM, W_DATA:** s_wready=1. On each W handshake:
  - If burst==INCR, write the enabled bytes.
  - Increment the counter.
  - The beat where counter==len ends the burst and moves to W_RESP, regardless of s_wlast.
- **Write FSM, W_RESP:** s_bvalid=1. s_bresp is SLVERR (2'b10) if burst!=INCR, or if s_wlast was seen on any beat other than the final one, or was missing on the final one. Otherwise s_bresp is OKAY (2'b00). The B handshake moves to W_IDLE.
- **Read FSM, R_IDLE:** s_arready=1. An AR handshake captures index, len and burst and moves to R_FETCH.
- **Read FSM, R_FETCH:** one cycle of synchronous array read, then move to R_DATA.
- **Read FSM, R_DATA:**
  - s_rvalid=1.
  - s_rdata: the fetched word, or 0 if burst!=INCR.
  - s_rresp: SLVERR if burst!=INCR, else OKAY.
  - s_rlast=1 when counter==len.
  - On an R handshake: go to R_IDLE if this was the last beat, else to R_FETCH with index+1.
- R outputs and B outputs hold stable while valid is high and ready is low.
- The write and read FSMs are fully independent. If a fetch and a write hit the same word in the same cycle, the fetch returns the old data (read-before-write).
- The array is not reset. Reading an unwritten word returns an undefined value.
## Timing
- **Reset values:** all outputs are 0 while reset is high, including s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast, s_rdata and s_rresp. FSMs reset to IDLE. s_awready and s_arready rise on the first rising edge after reset is released.
- **Write path:** AW handshake at edge N gives s_wready=1 from N+1. The final W handshake at edge M gives s_bvalid=1 from M+1. After the B handshake, s_awready=1 on the next cycle.
- **Read path:** AR handshake at edge N gives s_rvalid=1 from N+2. A non-last R handshake at edge K gives the next s_rvalid from K+2. Throughput is one beat per two cycles.
- **Reset mid-burst:** the in-flight transaction is discarded with no response, and array writes already done are kept.
## Structure
- Package axi_mem_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - BURST_FIXED/INCR/WRAP
  - enums wr_state_t {W_IDLE,W_DATA,W_RESP} and rd_state_t {R_IDLE,R_FETCH,R_DATA}
- Sub-module axi_mem_array: DEPTH x DATA_WIDTH array with one byte-enabled write port and one synchronous read port, no reset.
## Test plan
- **Single write then read:** write 0xDEADBEEF to 0x10 with strb 0xF. Required: bresp OKAY one cycle after the W handshake. Then read 0x10, len 0. Required: rdata 0xDEADBEEF, rlast=1, OKAY, rvalid two cycles after AR.
- **INCR burst:** write 0x100, len 3, data 1,2,3,4. Then read it back with len 3. Required: data 1,2,3,4 with rlast on beat 4 only.
- **Byte strobes:** write 0xFFFFFFFF, then 0x00000000 with strb 0x5 to the same word. Required: read returns 0xFF00FF00.
- **FIXED write:** awburst FIXED, len 1. Required: two beats accepted, memory unchanged, bresp SLVERR.
- **WRAP read:** arburst WRAP, len 1. Required: two beats with rdata 0, SLVERR, rlast on beat 2.
- **Early wlast:** s_wlast on beat 1 of a len-3 write. Required: four beats still consumed and bresp SLVERR.
- **Wrap-around write:** write at word DEPTH-1, len 1. Required: beat 2 lands in word 0.
- **Reset mid-read-burst:** assert reset. Required: s_rvalid goes to 0 asynchronously, and s_arready=1 one edge after release.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// Shared constants and FSM state types for the AXI4 burst memory slave.
package axi_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } rd_state_t;

  function automatic logic [1:0] burst_resp(
    input logic [1:0] burst,
    input logic       err
  );
    return (burst != BURST_INCR || err) ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word array: one byte-enabled write port, one registered read port.
// Deliberately unreset so contents survive a bus reset.
module axi_mem_array #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32,
  localparam int BYTES     = DATA_WIDTH / 8,
  localparam int IDXW      = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  we_i,
  input  logic [IDXW-1:0]       widx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BYTES-1:0]      wstrb_i,
  input  logic                  re_i,
  input  logic [IDXW-1:0]       ridx_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Nonblocking update gives read-before-write on a same-word collision.
  always_ff @(posedge clock) begin
    if (re_i) begin
      rdata_o <= mem_q[ridx_i];
    end
    if (we_i) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb_i[b]) begin
          mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 INCR-burst memory slave with independent write and read FSMs.
// Non-INCR bursts complete normally but answer SLVERR without touching memory.
module axi_burst_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  localparam int BYTES     = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic [1:0]            s_awburst,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [BYTES-1:0]      s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [1:0]            s_arburst,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int OFFW = $clog2(BYTES);
  localparam logic [IDXW-1:0] IDX_ONE = 1;

  // Held low through reset so both address readies rise one edge after release.
  logic live_q;

  wr_state_t       ws_q, ws_d;
  logic [IDXW-1:0] widx_q, widx_d;
  logic [7:0]      wlen_q, wlen_d;
  logic [7:0]      wcnt_q, wcnt_d;
  logic [1:0]      wburst_q, wburst_d;
  logic            werr_q, werr_d;
  logic            w_last;
  logic            mem_we;

  rd_state_t       rs_q, rs_d;
  logic [IDXW-1:0] ridx_q, ridx_d;
  logic [7:0]      rlen_q, rlen_d;
  logic [7:0]      rcnt_q, rcnt_d;
  logic [1:0]      rburst_q, rburst_d;
  logic            mem_re;
  logic [DATA_WIDTH-1:0] rd_word;

  logic unused_addr;
  assign unused_addr = ^{s_awaddr, s_araddr};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      live_q   <= 1'b0;
      ws_q     <= W_IDLE;
      widx_q   <= '0;
      wlen_q   <= '0;
      wcnt_q   <= '0;
      wburst_q <= '0;
      werr_q   <= 1'b0;
      rs_q     <= R_IDLE;
      ridx_q   <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rburst_q <= '0;
    end else begin
      live_q   <= 1'b1;
      ws_q     <= ws_d;
      widx_q   <= widx_d;
      wlen_q   <= wlen_d;
      wcnt_q   <= wcnt_d;
      wburst_q <= wburst_d;
      werr_q   <= werr_d;
      rs_q     <= rs_d;
      ridx_q   <= ridx_d;
      rlen_q   <= rlen_d;
      rcnt_q   <= rcnt_d;
      rburst_q <= rburst_d;
    end
  end

  always_comb begin
    ws_d      = ws_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    wburst_d  = wburst_q;
    werr_d    = werr_q;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = RESP_OKAY;
    mem_we    = 1'b0;
    w_last    = (wcnt_q == wlen_q);
    unique case (ws_q)
      W_IDLE: begin
        s_awready = live_q;
        if (live_q && s_awvalid) begin
          ws_d     = W_DATA;
          widx_d   = s_awaddr[IDXW+OFFW-1:OFFW];
          wlen_d   = s_awlen;
          wburst_d = s_awburst;
          wcnt_d   = '0;
          werr_d   = 1'b0;
        end
      end
      W_DATA: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          mem_we = (wburst_q == BURST_INCR);
          widx_d = widx_q + IDX_ONE;
          wcnt_d = wcnt_q + 8'd1;
          // Length decides the end; wlast only grades the response.
          werr_d = werr_q | (s_wlast != w_last);
          if (w_last) ws_d = W_RESP;
        end
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        s_bresp  = burst_resp(wburst_q, werr_q);
        if (s_bready) ws_d = W_IDLE;
      end
      default: ws_d = W_IDLE;
    endcase
  end

  always_comb begin
    rs_d      = rs_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rburst_d  = rburst_q;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rlast   = 1'b0;
    s_rresp   = RESP_OKAY;
    s_rdata   = '0;
    mem_re    = 1'b0;
    unique case (rs_q)
      R_IDLE: begin
        s_arready = live_q;
        if (live_q && s_arvalid) begin
          rs_d     = R_FETCH;
          ridx_d   = s_araddr[IDXW+OFFW-1:OFFW];
          rlen_d   = s_arlen;
          rburst_d = s_arburst;
          rcnt_d   = '0;
        end
      end
      R_FETCH: begin
        mem_re = 1'b1;
        rs_d   = R_DATA;
      end
      R_DATA: begin
        s_rvalid = 1'b1;
        s_rlast  = (rcnt_q == rlen_q);
        s_rresp  = burst_resp(rburst_q, 1'b0);
        if (rburst_q == BURST_INCR) s_rdata = rd_word;
        if (s_rready) begin
          if (s_rlast) begin
            rs_d = R_IDLE;
          end else begin
            rs_d   = R_FETCH;
            ridx_d = ridx_q + IDX_ONE;
            rcnt_d = rcnt_q + 8'd1;
          end
        end
      end
      default: rs_d = R_IDLE;
    endcase
  end

  axi_mem_array #(
    .DEPTH     (DEPTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clock  (clock),
    .we_i   (mem_we),
    .widx_i (widx_q),
    .wdata_i(s_wdata),
    .wstrb_i(s_wstrb),
    .re_i   (mem_re),
    .ridx_i (ridx_q),
    .rdata_o(rd_word)
  );

endmodule
